axi_lite_reg_slave: RTL and testbench

AXI_LITE_REG_SLAVE -- requirements
Module: axi_lite_reg_slave

---
 rtl/axi_lite_reg_slave_if.sv | 55 +++++
 rtl/axi_lite_reg_slave.sv | 207 ++++++++++++++++++++
 tb/tb_axi_lite_reg_slave.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_reg_slave_if.sv
// AXI4-Lite bus bundle for the register slave: master drives requests,
// slave drives readies and responses.
interface axi_lite_reg_slave_if #(
  parameter int ADDR_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] AWADDR;
  logic [2:0]            AWPROT;
  logic                  AWVALID;
  logic                  AWREADY;

  logic [31:0]           WDATA;
  logic [3:0]            WSTRB;
  logic                  WVALID;
  logic                  WREADY;

  logic [1:0]            BRESP;
  logic                  BVALID;
  logic                  BREADY;

  logic [ADDR_WIDTH-1:0] ARADDR;
  logic [2:0]            ARPROT;
  logic                  ARVALID;
  logic                  ARREADY;

  logic [31:0]           RDATA;
  logic [1:0]            RRESP;
  logic                  RVALID;
  logic                  RREADY;

  modport slave (
    input  AWADDR, AWPROT, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WVALID,
    output WREADY,
    output BRESP, BVALID,
    input  BREADY,
    input  ARADDR, ARPROT, ARVALID,
    output ARREADY,
    output RDATA, RRESP, RVALID,
    input  RREADY
  );

  modport master (
    output AWADDR, AWPROT, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WVALID,
    input  WREADY,
    input  BRESP, BVALID,
    output BREADY,
    output ARADDR, ARPROT, ARVALID,
    input  ARREADY,
    input  RDATA, RRESP, RVALID,
    output RREADY
  );
endinterface

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit registers with byte strobes.
// Define AXI_LITE_REG_SLVERR_EN to answer out-of-range accesses with SLVERR.
module axi_lite_reg_slave #(
  parameter int          NUM_REGS   = 8,
  parameter int          ADDR_WIDTH = 16,
  parameter logic [31:0] RESET_VAL  = 32'h0000_0000
) (
  input  logic                     ACLK,
  input  logic                     ARESETn,
  axi_lite_reg_slave_if.slave      s_axi,
  output logic [NUM_REGS*32-1:0]   reg_q,
  output logic [NUM_REGS-1:0]      wr_pulse
);

  localparam int SEL_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

`ifdef AXI_LITE_REG_SLVERR_EN
  localparam logic [1:0] OOR_RESP = 2'b10;
`else
  localparam logic [1:0] OOR_RESP = 2'b00;
`endif
  localparam logic [1:0] OKAY_RESP = 2'b00;

  // Handshakes: a transfer happens on a rising edge where VALID and READY
  // are both 1. Readies are pure functions of registered state, never of VALID.

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return 64'(a[ADDR_WIDTH-1:2]) < 64'(NUM_REGS);
  endfunction

  function automatic logic [SEL_W-1:0] reg_sel(input logic [ADDR_WIDTH-1:0] a);
    return a[SEL_W+1:2];
  endfunction

  // Write-side state
  logic                  aw_held_q, aw_held_d;
  logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic                  w_held_q, w_held_d;
  logic [31:0]           w_data_q, w_data_d;
  logic [3:0]            w_strb_q, w_strb_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;
  logic [31:0]           regs_q [NUM_REGS];
  logic [31:0]           regs_d [NUM_REGS];

  // Read-side state
  logic                  rvalid_q, rvalid_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;

  logic awready, wready, arready;
  logic aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic commit;
  logic commit_in_range;
  logic [SEL_W-1:0] wsel;
  logic [SEL_W-1:0] rsel;

  assign awready = !aw_held_q && !bvalid_q;
  assign wready  = !w_held_q  && !bvalid_q;
  assign arready = !rvalid_q;

  assign aw_hs = s_axi.AWVALID && awready;
  assign w_hs  = s_axi.WVALID  && wready;
  assign ar_hs = s_axi.ARVALID && arready;
  assign b_hs  = bvalid_q && s_axi.BREADY;
  assign r_hs  = rvalid_q && s_axi.RREADY;

  // Address and data are both parked before the commit edge, so the commit
  // works purely from the held copies.
  assign commit          = aw_held_q && w_held_q;
  assign commit_in_range = in_range(aw_addr_q);
  assign wsel            = reg_sel(aw_addr_q);
  assign rsel            = reg_sel(s_axi.ARADDR);

  always_comb begin
    aw_held_d  = aw_held_q;
    aw_addr_d  = aw_addr_q;
    w_held_d   = w_held_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    wr_pulse_d = '0;
    regs_d     = regs_q;

    if (b_hs) begin
      bvalid_d = 1'b0;
    end

    if (aw_hs) begin
      aw_held_d = 1'b1;
      aw_addr_d = s_axi.AWADDR;
    end

    if (w_hs) begin
      w_held_d = 1'b1;
      w_data_d = s_axi.WDATA;
      w_strb_d = s_axi.WSTRB;
    end

    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      if (commit_in_range) begin
        for (int b = 0; b < 4; b++) begin
          if (w_strb_q[b]) begin
            regs_d[wsel][8*b +: 8] = w_data_q[8*b +: 8];
          end
        end
        wr_pulse_d[wsel] = 1'b1;
        bresp_d          = OKAY_RESP;
      end else begin
        bresp_d = OOR_RESP;
      end
    end
  end

  // Read data comes from regs_q, so a same-edge commit is not yet visible.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;

    if (r_hs) begin
      rvalid_d = 1'b0;
    end

    if (ar_hs) begin
      rvalid_d = 1'b1;
      if (in_range(s_axi.ARADDR)) begin
        rdata_d = regs_q[rsel];
        rresp_d = OKAY_RESP;
      end else begin
        rdata_d = 32'h0000_0000;
        rresp_d = OOR_RESP;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      aw_held_q  <= 1'b0;
      aw_addr_q  <= '0;
      w_held_q   <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= 2'b00;
      wr_pulse_q <= '0;
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= RESET_VAL;
      end
    end else begin
      aw_held_q  <= aw_held_d;
      aw_addr_q  <= aw_addr_d;
      w_held_q   <= w_held_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      wr_pulse_q <= wr_pulse_d;
      regs_q     <= regs_d;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rvalid_q <= 1'b0;
      rdata_q  <= 32'h0000_0000;
      rresp_q  <= 2'b00;
    end else begin
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
    end
  end

  assign s_axi.AWREADY = awready;
  assign s_axi.WREADY  = wready;
  assign s_axi.BVALID  = bvalid_q;
  assign s_axi.BRESP   = bresp_q;
  assign s_axi.ARREADY = arready;
  assign s_axi.RVALID  = rvalid_q;
  assign s_axi.RDATA   = rdata_q;
  assign s_axi.RRESP   = rresp_q;
  assign wr_pulse      = wr_pulse_q;

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
    assign reg_q[32*k +: 32] = regs_q[k];
  end

  // Protection bits and the byte-lane address bits carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{s_axi.AWPROT, s_axi.ARPROT, aw_addr_q[1:0], s_axi.ARADDR[1:0]};

  a_b_hold: assert property (@(posedge ACLK) disable iff (!ARESETn)
    bvalid_q && !s_axi.BREADY |=> bvalid_q && $stable(bresp_q));

  a_r_hold: assert property (@(posedge ACLK) disable iff (!ARESETn)
    rvalid_q && !s_axi.RREADY |=> rvalid_q && $stable(rdata_q) && $stable(rresp_q));

  a_pulse_onehot: assert property (@(posedge ACLK) disable iff (!ARESETn)
    $onehot0(wr_pulse_q));

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Directed bench for axi_lite_reg_slave: vector table plus hand-written
// sequences for write ordering, back-pressure, read/commit collision and reset.
module tb_axi_lite_reg_slave;
  localparam int          NUM_REGS = 8;
  localparam int          AW       = 16;
  localparam logic [31:0] RV       = 32'h0BAD_F00D;
`ifdef AXI_LITE_REG_SLVERR_EN
  localparam logic [1:0]  OOR      = 2'b10;
`else
  localparam logic [1:0]  OOR      = 2'b00;
`endif

  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;
  logic [NUM_REGS*32-1:0] reg_q;
  logic [NUM_REGS-1:0]    wr_pulse;

  axi_lite_reg_slave_if #(.ADDR_WIDTH(AW)) bus ();

  axi_lite_reg_slave #(
    .NUM_REGS  (NUM_REGS),
    .ADDR_WIDTH(AW),
    .RESET_VAL (RV)
  ) dut (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .s_axi   (bus.slave),
    .reg_q   (reg_q),
    .wr_pulse(wr_pulse)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic        is_rd;
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
    logic [7:0]  exp_pulse;
  } vec_t;

  vec_t        vecs[12];
  logic [31:0] mdl[NUM_REGS];
  int          n_chk  = 0;
  int          n_pass = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [255:0] mdl_flat();
    logic [255:0] f;
    for (int k = 0; k < NUM_REGS; k++) f[32*k +: 32] = mdl[k];
    return f;
  endfunction

  task automatic mdl_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
    if (a[15:2] < 14'(NUM_REGS)) begin
      for (int b = 0; b < 4; b++) if (s[b]) mdl[a[4:2]][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    @(negedge ACLK);
  endtask

  // Called at a falling edge with the bus idle; AW and W are offered together.
  task automatic do_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [1:0] er, input logic [7:0] ep, input string tag);
    check({tag, "_awready"}, 256'(bus.AWREADY), 256'(1'b1));
    check({tag, "_wready"}, 256'(bus.WREADY), 256'(1'b1));
    bus.AWADDR = a; bus.AWVALID = 1'b1;
    bus.WDATA = d;  bus.WSTRB = s; bus.WVALID = 1'b1;
    bus.BREADY = 1'b1;
    tick();
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    check({tag, "_bvalid_early"}, 256'(bus.BVALID), 256'(1'b0));
    tick();
    check({tag, "_bvalid"}, 256'(bus.BVALID), 256'(1'b1));
    check({tag, "_bresp"}, 256'(bus.BRESP), 256'(er));
    check({tag, "_pulse"}, 256'(wr_pulse), 256'(ep));
    tick();
    check({tag, "_bvalid_clr"}, 256'(bus.BVALID), 256'(1'b0));
    check({tag, "_pulse_clr"}, 256'(wr_pulse), 256'(0));
    bus.BREADY = 1'b0;
  endtask

  task automatic do_read(input logic [15:0] a, input logic [31:0] ed, input logic [1:0] er,
                         input string tag);
    check({tag, "_arready"}, 256'(bus.ARREADY), 256'(1'b1));
    bus.ARADDR = a; bus.ARVALID = 1'b1; bus.RREADY = 1'b0;
    tick();
    bus.ARVALID = 1'b0;
    check({tag, "_rvalid"}, 256'(bus.RVALID), 256'(1'b1));
    check({tag, "_rdata"}, 256'(bus.RDATA), 256'(ed));
    check({tag, "_rresp"}, 256'(bus.RRESP), 256'(er));
    bus.RREADY = 1'b1;
    tick();
    bus.RREADY = 1'b0;
    check({tag, "_rvalid_clr"}, 256'(bus.RVALID), 256'(1'b0));
  endtask

  initial begin
    bus.AWADDR = '0; bus.AWPROT = 3'b000; bus.AWVALID = 1'b0;
    bus.WDATA = '0;  bus.WSTRB = 4'h0;    bus.WVALID = 1'b0;
    bus.BREADY = 1'b0;
    bus.ARADDR = '0; bus.ARPROT = 3'b000; bus.ARVALID = 1'b0;
    bus.RREADY = 1'b0;
    for (int k = 0; k < NUM_REGS; k++) mdl[k] = RV;

    // Reset state
    repeat (3) @(negedge ACLK);
    check("rst_bvalid", 256'(bus.BVALID), 256'(0));
    check("rst_rvalid", 256'(bus.RVALID), 256'(0));
    check("rst_rdata", 256'(bus.RDATA), 256'(0));
    check("rst_readies", 256'({bus.AWREADY, bus.WREADY, bus.ARREADY}), 256'(3'b111));
    check("rst_pulse", 256'(wr_pulse), 256'(0));
    check("rst_regs", reg_q, mdl_flat());
    ARESETn = 1'b1;
    @(negedge ACLK);

    //          rd    addr      data          strb  exp_rdata     resp   pulse
    vecs[0]  = '{1'b1, 16'h000C, 32'h0,        4'h0, RV,           2'b00, 8'h00};
    vecs[1]  = '{1'b0, 16'h0008, 32'hDEADBEEF, 4'hF, 32'h0,        2'b00, 8'h04};
    vecs[2]  = '{1'b1, 16'h0008, 32'h0,        4'h0, 32'hDEADBEEF, 2'b00, 8'h00};
    vecs[3]  = '{1'b0, 16'h0000, 32'h12345678, 4'hF, 32'h0,        2'b00, 8'h01};
    vecs[4]  = '{1'b0, 16'h0011, 32'h0000CAFE, 4'h3, 32'h0,        2'b00, 8'h10};
    vecs[5]  = '{1'b1, 16'h0013, 32'h0,        4'h0, 32'h0BADCAFE, 2'b00, 8'h00};
    vecs[6]  = '{1'b0, 16'h001C, 32'hFFFFFFFF, 4'h0, 32'h0,        2'b00, 8'h80};
    vecs[7]  = '{1'b0, 16'h0040, 32'h11111111, 4'hF, 32'h0,        OOR,   8'h00};
    vecs[8]  = '{1'b1, 16'h0040, 32'h0,        4'h0, 32'h0,        OOR,   8'h00};
    vecs[9]  = '{1'b0, 16'h001C, 32'hA1B2C3D4, 4'hA, 32'h0,        2'b00, 8'h80};
    vecs[10] = '{1'b1, 16'h001C, 32'h0,        4'h0, 32'hA1ADC30D, 2'b00, 8'h00};
    vecs[11] = '{1'b1, 16'h0004, 32'h0,        4'h0, RV,           2'b00, 8'h00};

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].is_rd) begin
        do_read(vecs[i].addr, vecs[i].exp_rdata, vecs[i].exp_resp, $sformatf("v%0d", i));
      end else begin
        do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].exp_resp,
                 vecs[i].exp_pulse, $sformatf("v%0d", i));
        mdl_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
        check($sformatf("v%0d_regs", i), reg_q, mdl_flat());
      end
    end

    // W arrives three cycles ahead of AW
    bus.WDATA = 32'h000000AA; bus.WSTRB = 4'b0001; bus.WVALID = 1'b1; bus.BREADY = 1'b1;
    tick();
    bus.WVALID = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("wfirst_c%0d_rdy", c), 256'({bus.AWREADY, bus.WREADY, bus.BVALID}),
            256'(3'b100));
      tick();
    end
    bus.AWADDR = 16'h0000; bus.AWVALID = 1'b1;
    tick();
    bus.AWVALID = 1'b0;
    check("wfirst_bvalid_early", 256'(bus.BVALID), 256'(0));
    tick();
    check("wfirst_bvalid", 256'(bus.BVALID), 256'(1));
    check("wfirst_pulse", 256'(wr_pulse), 256'(8'h01));
    mdl_write(16'h0000, 32'h000000AA, 4'b0001);
    check("wfirst_reg0", 256'(reg_q[31:0]), 256'(32'h123456AA));
    tick();
    bus.BREADY = 1'b0;

    // B back-pressure for 5 cycles with a second write waiting
    bus.AWADDR = 16'h0014; bus.AWVALID = 1'b1;
    bus.WDATA = 32'h5; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
    tick();
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    tick();
    bus.AWADDR = 16'h0018; bus.AWVALID = 1'b1;
    bus.WDATA = 32'h6; bus.WVALID = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bstall_c%0d", c),
            256'({bus.BVALID, bus.BRESP, bus.AWREADY, bus.WREADY}), 256'(5'b1_00_00));
      tick();
    end
    bus.BREADY = 1'b1;
    tick();
    check("bstall_release", 256'({bus.BVALID, bus.AWREADY, bus.WREADY}), 256'(3'b011));
    tick();
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    tick();
    check("bstall_second_bvalid", 256'(bus.BVALID), 256'(1));
    check("bstall_second_pulse", 256'(wr_pulse), 256'(8'h40));
    mdl_write(16'h0014, 32'h5, 4'hF);
    mdl_write(16'h0018, 32'h6, 4'hF);
    check("bstall_regs", reg_q, mdl_flat());
    tick();
    bus.BREADY = 1'b0;

    // Read and commit to the same register on the same edge
    do_write(16'h0004, 32'h11, 4'hF, 2'b00, 8'h02, "coll_pre");
    mdl_write(16'h0004, 32'h11, 4'hF);
    bus.AWADDR = 16'h0004; bus.AWVALID = 1'b1;
    bus.WDATA = 32'h55; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
    bus.BREADY = 1'b1; bus.RREADY = 1'b0;
    tick();
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    bus.ARADDR = 16'h0004; bus.ARVALID = 1'b1;
    tick();
    bus.ARVALID = 1'b0;
    check("coll_rvalid", 256'(bus.RVALID), 256'(1));
    check("coll_rdata_old", 256'(bus.RDATA), 256'(32'h11));
    check("coll_bvalid", 256'(bus.BVALID), 256'(1));
    check("coll_pulse", 256'(wr_pulse), 256'(8'h02));
    bus.RREADY = 1'b1;
    tick();
    bus.RREADY = 1'b0; bus.BREADY = 1'b0;
    mdl_write(16'h0004, 32'h55, 4'hF);
    do_read(16'h0004, 32'h55, 2'b00, "coll_post");

    // Reset with W held and a read response pending
    bus.WDATA = 32'hFFFFFFFF; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
    bus.ARADDR = 16'h0008; bus.ARVALID = 1'b1;
    tick();
    bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
    check("mid_pending", 256'({bus.RVALID, bus.WREADY}), 256'(2'b10));
    #2 ARESETn = 1'b0;
    #1;
    for (int k = 0; k < NUM_REGS; k++) mdl[k] = RV;
    check("mid_rst_out", 256'({bus.RVALID, bus.BVALID, bus.RDATA, wr_pulse}), 256'(0));
    check("mid_rst_readies", 256'({bus.AWREADY, bus.WREADY, bus.ARREADY}), 256'(3'b111));
    check("mid_rst_regs", reg_q, mdl_flat());
    @(negedge ACLK);
    ARESETn = 1'b1;
    @(negedge ACLK);
    bus.AWADDR = 16'h0008; bus.AWVALID = 1'b1; bus.BREADY = 1'b1;
    tick();
    bus.AWVALID = 1'b0;
    tick();
    check("mid_no_commit", 256'(bus.BVALID), 256'(0));
    check("mid_regs_kept", reg_q, mdl_flat());
    bus.WDATA = 32'h77; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
    tick();
    bus.WVALID = 1'b0;
    tick();
    check("mid_late_bvalid", 256'(bus.BVALID), 256'(1));
    check("mid_late_pulse", 256'(wr_pulse), 256'(8'h04));
    mdl_write(16'h0008, 32'h77, 4'hF);
    check("mid_late_regs", reg_q, mdl_flat());
    tick();
    bus.BREADY = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
